// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared types and constants for the traffic_sequencer slice.
//   state_e      : six-state signal sequence, in cycling order
//   LAMP_*       : one-hot lamp codes {red,yellow,green}
//   DWELL_W      : width of the dwell counter / sec_left
//   next_state() : successor in the fixed cycle
//   lamp_decode(): state -> {ns, ew} lamp codes
package traffic_pkg;

    localparam int DWELL_W = 8;
    typedef logic [DWELL_W-1:0] dwell_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_EW = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_NS = 3'd5
    } state_e;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    function automatic state_e next_state(input state_e s);
        state_e n;
        case (s)
            ST_NS_GREEN:  n = ST_NS_YELLOW;
            ST_NS_YELLOW: n = ST_ALLRED_EW;
            ST_ALLRED_EW: n = ST_EW_GREEN;
            ST_EW_GREEN:  n = ST_EW_YELLOW;
            ST_EW_YELLOW: n = ST_ALLRED_NS;
            default:      n = ST_NS_GREEN;
        endcase
        return n;
    endfunction

    // Anything not explicitly green/yellow decodes to all-red, so an
    // illegal state code can never show two non-red lamps.
    function automatic lamps_t lamp_decode(input state_e s);
        lamps_t l;
        l.ns = LAMP_RED;
        l.ew = LAMP_RED;
        case (s)
            ST_NS_GREEN:  l.ns = LAMP_GREEN;
            ST_NS_YELLOW: l.ns = LAMP_YELLOW;
            ST_EW_GREEN:  l.ew = LAMP_GREEN;
            ST_EW_YELLOW: l.ew = LAMP_YELLOW;
            default:      ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_sequencer_dwell_timer.sv
// dwell_timer -- loadable down-counter paced by the 1 Hz tick.
//   clk, rst : clock, asynchronous active-high reset (count <= RST_VAL)
//   load     : load load_val this edge (wins over tick)
//   load_val : value loaded on state entry (duration-1)
//   tick     : decrement enable; counter saturates at zero
//   count    : registered counter value
//   zero     : count == 0
module dwell_timer
    import traffic_pkg::*;
#(
    parameter int     W       = DWELL_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && !zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer -- two-road intersection controller with pedestrian walk.
//   clk        : system clock, all state on rising edge
//   rst        : asynchronous active-high reset (restarts in ALLRED_NS)
//   tick       : one-clk 1 Hz enable, the only time base
//   ew_sensor  : east-west vehicle present
//   ped_req    : pedestrian request to cross the NS road
//   ns_light   : NS lamp, one-hot {red,yellow,green}, registered
//   ew_light   : EW lamp, same encoding, registered
//   walk       : walk lamp, lit for a whole EW green if requested before it
//   sec_left   : ticks remaining in the current state minus one
// NS is the default road: it stays green after its minimum dwell until an
// EW vehicle or pedestrian request is pending. Parameters are legal 1..255.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               ew_sensor,
    input  logic               ped_req,
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic               walk,
    output logic [DWELL_W-1:0] sec_left
);

    localparam dwell_t GREEN_LD  = dwell_t'(GREEN_SEC - 1);
    localparam dwell_t YELLOW_LD = dwell_t'(YELLOW_SEC - 1);
    localparam dwell_t ALLRED_LD = dwell_t'(ALLRED_SEC - 1);

    function automatic dwell_t dwell_load(input state_e s);
        dwell_t d;
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   d = GREEN_LD;
            ST_NS_YELLOW, ST_EW_YELLOW: d = YELLOW_LD;
            default:                    d = ALLRED_LD;
        endcase
        return d;
    endfunction

    state_e state;
    state_e state_nxt;
    logic   advance;
    logic   enter_ew;
    logic   ew_pending;
    logic   ped_pending;
    dwell_t cnt;
    logic   cnt_zero;
    lamps_t lamps_nxt;

    // Leave a state on the tick that finds the counter at zero, except
    // NS green which additionally waits for a pending EW request.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        if (tick && cnt_zero && !(state == ST_NS_GREEN && !ew_pending)) begin
            advance   = 1'b1;
            state_nxt = next_state(state);
        end
    end

    assign enter_ew  = advance && (state_nxt == ST_EW_GREEN);
    assign lamps_nxt = lamp_decode(state_nxt);

    dwell_timer #(
        .W       (DWELL_W),
        .RST_VAL (ALLRED_LD)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (advance),
        .load_val (dwell_load(state_nxt)),
        .tick     (tick),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_ALLRED_NS;
        else
            state <= state_nxt;
    end

    // Requests arriving during EW green are already being served, so they
    // do not re-arm ew_pending; the entry edge clears, overriding any set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ew_pending  <= 1'b0;
            ped_pending <= 1'b0;
        end else if (enter_ew) begin
            ew_pending  <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            if ((ew_sensor || ped_req) && state != ST_EW_GREEN)
                ew_pending <= 1'b1;
            if (ped_req)
                ped_pending <= 1'b1;
        end
    end

    // Lamps and walk are registered from the next-state decode so they
    // change on the same edge as the state, with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
            walk     <= 1'b0;
        end else begin
            ns_light <= lamps_nxt.ns;
            ew_light <= lamps_nxt.ew;
            if (enter_ew)
                walk <= ped_pending;
            else if (state_nxt != ST_EW_GREEN)
                walk <= 1'b0;
        end
    end

    // The counter itself is a register, so sec_left is registered as well.
    assign sec_left = cnt;

endmodule

// File: tb/tb_traffic_sequencer.sv
module tb_traffic_sequencer;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ew_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic       walk;
    logic [7:0] sec_left;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    traffic_sequencer #(
        .GREEN_SEC  (5),
        .YELLOW_SEC (2),
        .ALLRED_SEC (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .ew_sensor (ew_sensor),
        .ped_req   (ped_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .walk      (walk),
        .sec_left  (sec_left)
    );

    // One row per tick period: ew/ped pulse on the first clk of the period,
    // ewt holds ew_sensor high on the tick clk; expected outputs after the tick.
    typedef struct packed {
        logic       ew;
        logic       ped;
        logic       ewt;
        logic [2:0] ns;
        logic [2:0] ewl;
        logic       w;
        logic [7:0] sec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ew, input logic ped, input logic ewt,
                       input logic [2:0] ns, input logic [2:0] ewl,
                       input logic w, input int sec);
        vec_t v;
        v.ew = ew; v.ped = ped; v.ewt = ewt;
        v.ns = ns; v.ewl = ewl; v.w = w; v.sec = 8'(sec);
        tbl.push_back(v);
    endtask

    function automatic logic [14:0] obs();
        return {ns_light, ew_light, walk, sec_left};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ns=%b ew=%b walk=%b sec=%0d, want ns=%b ew=%b walk=%b sec=%0d",
                      name, act[14:12], act[11:9], act[8], act[7:0],
                      exp[14:12], exp[11:9], exp[8], exp[7:0]);
    endtask

    // Drive one clock with the given tick, sample #1 after the edge.
    task automatic clk1(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic period();
        repeat (9) clk1(1'b0);
        clk1(1'b1);
    endtask

    // Safety: never two non-red lamps, checked every cycle.
    always @(negedge clk) begin
        n_tot++;
        if (ns_light != R && ew_light != R)
            $display("FAIL lamp_conflict: got ns=%b ew=%b, want at least one 100", ns_light, ew_light);
        else
            n_pass++;
    end

    initial begin
        logic [14:0] prev;

        // NS green holds at zero with no demand.
        for (int s = 4; s >= 0; s--) add(0, 0, 0, G, R, 0, s);
        add(0, 0, 0, G, R, 0, 0);
        add(0, 0, 0, G, R, 0, 0);
        // Demand at held zero releases on the next tick; ped during yellow.
        add(1, 0, 0, Y, R, 0, 1);
        add(0, 1, 0, Y, R, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        add(0, 0, 0, R, G, 1, 4);
        add(0, 0, 0, R, G, 1, 3);
        add(0, 1, 0, R, G, 1, 2);           // ped during EW green
        add(0, 0, 0, R, G, 1, 1);
        add(0, 0, 0, R, G, 1, 0);
        add(0, 0, 0, R, Y, 0, 1);
        add(0, 0, 0, R, Y, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        // EW pulse early in NS green: full 5/2/1/5/2 cycle, walk from EW-green ped.
        add(0, 0, 0, G, R, 0, 4);
        add(1, 0, 0, G, R, 0, 3);
        for (int s = 2; s >= 0; s--) add(0, 0, 0, G, R, 0, s);
        add(0, 0, 0, Y, R, 0, 1);
        add(0, 0, 0, Y, R, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        for (int s = 4; s >= 0; s--) add(0, 0, 0, R, G, 1, s);
        add(0, 0, 0, R, Y, 0, 1);
        add(0, 0, 0, R, Y, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        for (int s = 4; s >= 0; s--) add(0, 0, 0, G, R, 0, s);
        add(0, 0, 0, G, R, 0, 0);
        // No ped this time: walk stays 0; ew_sensor on the entry edge is dropped.
        add(1, 0, 0, Y, R, 0, 1);
        add(0, 0, 0, Y, R, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        add(0, 0, 1, R, G, 0, 4);
        for (int s = 3; s >= 0; s--) add(0, 0, 0, R, G, 0, s);
        add(0, 0, 0, R, Y, 0, 1);
        add(0, 0, 0, R, Y, 0, 0);
        add(0, 0, 0, R, R, 0, 0);
        for (int s = 4; s >= 0; s--) add(0, 0, 0, G, R, 0, s);
        add(0, 0, 0, G, R, 0, 0);
        add(0, 0, 0, G, R, 0, 0);

        // Reset state, including a tick while held in reset.
        repeat (3) clk1(1'b0);
        check("reset", obs(), {R, R, 1'b0, 8'd0});
        clk1(1'b1);
        check("reset_tick", obs(), {R, R, 1'b0, 8'd0});
        rst = 1'b0;

        prev = {R, R, 1'b0, 8'd0};
        for (int i = 0; i < tbl.size(); i++) begin
            ew_sensor = tbl[i].ew;
            ped_req   = tbl[i].ped;
            clk1(1'b0);
            ew_sensor = 1'b0;
            ped_req   = 1'b0;
            repeat (8) clk1(1'b0);
            check($sformatf("row%0d_pre", i), obs(), prev);
            ew_sensor = tbl[i].ewt;
            clk1(1'b1);
            ew_sensor = 1'b0;
            prev = {tbl[i].ns, tbl[i].ewl, tbl[i].w, tbl[i].sec};
            check($sformatf("row%0d", i), obs(), prev);
        end

        // Long tick-free stretch mid-yellow freezes everything.
        ew_sensor = 1'b1;
        clk1(1'b0);
        ew_sensor = 1'b0;
        ped_req = 1'b1;
        clk1(1'b0);
        ped_req = 1'b0;
        clk1(1'b1);
        check("yellow_entry", obs(), {Y, R, 1'b0, 8'd1});
        repeat (100) clk1(1'b0);
        check("no_tick_hold", obs(), {Y, R, 1'b0, 8'd1});
        period();
        period();
        period();
        check("ew_green_walk", obs(), {R, G, 1'b1, 8'd4});

        // Asynchronous reset between edges during EW green.
        #3 rst = 1'b1;
        #1 check("async_rst", obs(), {R, R, 1'b0, 8'd0});
        clk1(1'b0);
        clk1(1'b1);
        check("rst_held", obs(), {R, R, 1'b0, 8'd0});
        rst = 1'b0;
        repeat (9) clk1(1'b0);
        check("restart_allred", obs(), {R, R, 1'b0, 8'd0});
        clk1(1'b1);
        check("restart_ns_green", obs(), {G, R, 1'b0, 8'd4});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter GREEN_SEC, 10, minimum green dwell per direction, in ticks; legal 1..255.
REQ-002 Parameter YELLOW_SEC, 3, yellow dwell, in ticks; legal 1..255.
REQ-003 Parameter ALLRED_SEC, 2, all-red clearance dwell, in ticks; legal 1..255.
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port tick  input  1  one-cycle 1 Hz enable from the divider (oneHz_enable); sole time base.
REQ-007 Port ew_sensor  input  1  east-west vehicle-present level; synchronous to clk.
REQ-008 Port ped_req  input  1  pedestrian crossing request; synchronous to clk, sampled every clk.
REQ-009 Port ns_light  output  3  north-south lamp, one-hot {red,yellow,green}: 100, 010 or 001.
REQ-010 Port ew_light  output  3  east-west lamp, same encoding as ns_light.
REQ-011 Port walk  output  1  pedestrian walk lamp across NS road.
REQ-012 Port sec_left  output  8  ticks remaining in current state minus one.

Function
REQ-013 The FSM SHALL have six states cycling NS_GREEN -> NS_YELLOW -> ALLRED_EW -> EW_GREEN -> EW_YELLOW -> ALLRED_NS -> NS_GREEN.
REQ-014 On state entry, the dwell counter SHALL load duration-1: GREEN_SEC-1, YELLOW_SEC-1 or ALLRED_SEC-1.
REQ-015 The counter SHALL decrement only on clk edges where tick=1 and counter>0; no decrement without tick.
REQ-016 A transition SHALL occur on the clk edge where tick=1 and counter=0, so every state lasts exactly its duration in ticks.
REQ-017 Exception: in NS_GREEN with counter=0 and ew_pending=0, the FSM SHALL hold; counter stays 0; NS green persists indefinitely.
REQ-018 In NS_GREEN, transition to NS_YELLOW SHALL occur on the first tick with counter=0 and ew_pending=1.
REQ-019 ew_pending SHALL be set on any clk where ew_sensor=1 or ped_req=1 and the FSM is not in EW_GREEN.
REQ-020 ew_pending SHALL be cleared on the edge entering EW_GREEN; clear wins over a simultaneous set.
REQ-021 ped_pending SHALL be set by ped_req=1 in any state; it SHALL be cleared on entry to EW_GREEN, clear winning.
REQ-022 walk SHALL be 1 throughout EW_GREEN iff ped_pending was 1 on the entry edge; walk SHALL be 0 in all other states.
REQ-023 Lamp decode: NS_GREEN ns=001/ew=100; NS_YELLOW ns=010/ew=100; EW_GREEN ns=100/ew=001; EW_YELLOW ns=100/ew=010; ALLRED_* both 100.
REQ-024 All outputs SHALL be registered; no combinational input-to-output path.
REQ-025 Both lamps SHALL never be non-red simultaneously in any cycle.
REQ-026 sec_left SHALL equal the dwell counter value.

Reset
REQ-027 While rst=1, state SHALL be ALLRED_NS, counter ALLRED_SEC-1, ns_light=100, ew_light=100, walk=0, sec_left=ALLRED_SEC-1, ew_pending=0, ped_pending=0.
REQ-028 Reset asserted mid-state SHALL take effect immediately, without waiting for clk or tick; sequencing SHALL restart from ALLRED_NS on release.

Structure
REQ-029 Package traffic_pkg SHALL hold the state enum, the three lamp-code constants and the 8-bit dwell width constant.
REQ-030 The dwell counter SHALL be a sub-module dwell_timer with ports clk, rst, load, load_val, tick, count and zero.

Verification (GREEN_SEC=5, YELLOW_SEC=2, ALLRED_SEC=1, tick every 10 clk)
REQ-031 Reset release, ew_sensor=0 -> NS_GREEN after 1 tick; held beyond 5 ticks with sec_left=0 and ew_light=100.
REQ-032 ew_sensor one-clk pulse at tick 2 of NS_GREEN -> NS green exactly 5 ticks, yellow 2, all-red 1, EW green 5, EW yellow 2.
REQ-033 ped_req pulse during NS_YELLOW -> walk=1 for all 5 ticks of EW_GREEN and 0 elsewhere; ped_req during EW_GREEN -> walk on next EW_GREEN only.
REQ-034 ew_sensor=1 on the exact EW_GREEN entry edge -> ew_pending=0 afterwards; next NS_GREEN holds at counter 0.
REQ-035 rst pulse between clk edges during EW_GREEN -> both lamps 100, walk=0 before the next clk edge.
REQ-036 tick held 0 for 100 clk in any state -> no state or sec_left change; assertion checks REQ-025 every cycle.
